mont_final_sub_ctrl: RTL

- Limb-serial sequencer for the Montgomery final conditional subtraction: given T (< 2M) and modulus M, returns T-M if T >= M, else T.
- Shares one LIMB-wide subtract-with-borrow datapath (a - b - c, borrow out) across NBITS/LIMB limbs instead of a full-width subtractor.
- Sits between the Montgomery multiplier core output and the result consumer.
- Valid/ready handshakes on both sides.

---
 rtl/mont_final_sub_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/mont_final_sub_ctrl.sv
// Limb-serial Montgomery final conditional subtraction: y = (T >= M) ? T - M : T.
// Optional macro MFS_PIPE_ACCEPT_EN lets DONE accept new operands while retiring a result.
module mont_final_sub_ctrl #(
  parameter int NBITS = 256,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] t,
  input  logic [NBITS-1:0] m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] y,
  output logic             subtracted
);

  localparam int NLIMBS = NBITS / LIMB;
  localparam int CW     = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic              borrow;
  logic [NBITS-1:0]  t_reg, m_reg, diff;
  logic [LIMB-1:0]   t_limb, m_limb, d;
  logic              borrow_n;
  logic [NBITS-1:0]  diff_next;
  logic              last;
  logic              accept;

  // Select the current limb and merge its difference into the running result.
  always_comb begin
    t_limb    = '0;
    m_limb    = '0;
    diff_next = diff;
    for (int i = 0; i < NLIMBS; i++) begin
      if (CW'(i) == cnt) begin
        t_limb = t_reg[i*LIMB +: LIMB];
        m_limb = m_reg[i*LIMB +: LIMB];
        diff_next[i*LIMB +: LIMB] = d;
      end
    end
  end

  assign {borrow_n, d} = {1'b0, t_limb} - {1'b0, m_limb} - {{LIMB{1'b0}}, borrow};
  assign last          = (cnt == CW'(NLIMBS - 1));
  assign accept        = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SUB;
      end
      SUB: begin
        if (last) state_next = DONE;
      end
      DONE: begin
`ifdef MFS_PIPE_ACCEPT_EN
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? SUB : IDLE;
`else
        if (out_ready) state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // The final borrow decides between the raw T and the accumulated difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      borrow     <= 1'b0;
      t_reg      <= '0;
      m_reg      <= '0;
      diff       <= '0;
      y          <= '0;
      subtracted <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (state == DONE && out_ready) out_valid <= 1'b0;
      if (accept) begin
        t_reg  <= t;
        m_reg  <= m;
        cnt    <= '0;
        borrow <= 1'b0;
      end
      if (state == SUB) begin
        diff   <= diff_next;
        borrow <= borrow_n;
        cnt    <= last ? '0 : cnt + 1'b1;
        if (last) begin
          y          <= borrow_n ? t_reg : diff_next;
          subtracted <= ~borrow_n;
          out_valid  <= 1'b1;
        end
      end
    end
  end

endmodule
